// File: rtl/remote_comm.sv
// UART 8N1 link to the robot: sends a 16-bit command as two bytes (high first), receives 8-bit responses.
// TX starts the cycle after snd_cmd; resp/resp_rdy update one clock after the stop-bit sample; no backpressure.
module remote_comm #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, SEND_HIGH, SEND_LOW} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_BUSY, RX_DONE} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t     tx_state;
  logic [15:0]   cmd_reg;
  logic [3:0]    tx_bit;
  logic [BW-1:0] tx_baud;
  logic [9:0]    tx_frame;
  logic [3:0]    tx_bit_nxt;

  always_comb begin
    tx_frame   = (tx_state == SEND_HIGH) ? {1'b1, cmd_reg[15:8], 1'b0}
                                         : {1'b1, cmd_reg[7:0], 1'b0};
    tx_bit_nxt = tx_bit + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      tx_state <= IDLE;
      TX       <= 1'b1;
      cmd_snt  <= 1'b0;
      cmd_reg  <= 16'h0000;
      tx_bit   <= 4'd0;
      tx_baud  <= '0;
    end else begin
      case (tx_state)
        IDLE: begin
          if (snd_cmd) begin
            cmd_reg  <= cmd;
            cmd_snt  <= 1'b0;
            TX       <= 1'b0;
            tx_state <= SEND_HIGH;
            tx_bit   <= 4'd0;
            tx_baud  <= '0;
          end
        end
        default: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud <= '0;
            if (tx_bit == 4'd9) begin
              tx_bit <= 4'd0;
              // Low byte's start bit follows the high byte's stop bit with no idle gap.
              if (tx_state == SEND_HIGH) begin
                tx_state <= SEND_LOW;
                TX       <= 1'b0;
              end else begin
                tx_state <= IDLE;
                TX       <= 1'b1;
                cmd_snt  <= 1'b1;
              end
            end else begin
              tx_bit <= tx_bit_nxt;
              TX     <= tx_frame[tx_bit_nxt];
            end
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_t     rx_state;
  logic          rx_s1, rx_s2, rx_prev;
  logic [3:0]    rx_bit;
  logic [BW-1:0] rx_baud;
  logic [BW-1:0] rx_limit;
  logic [7:0]    rx_shift;

  always_comb begin
    rx_limit = (rx_bit == 4'd0) ? HALF_LAST : BAUD_LAST;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_bit   <= 4'd0;
      rx_baud  <= '0;
      rx_shift <= 8'h00;
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_BUSY;
            resp_rdy <= 1'b0;
            rx_bit   <= 4'd0;
            rx_baud  <= '0;
          end
        end
        RX_BUSY: begin
          if (rx_baud == rx_limit) begin
            rx_baud <= '0;
            // Only the eight data samples are kept; start and stop values are ignored.
            if (rx_bit >= 4'd1 && rx_bit <= 4'd8)
              rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 4'd9) begin
              rx_bit   <= 4'd0;
              rx_state <= RX_DONE;
            end else begin
              rx_bit <= rx_bit + 4'd1;
            end
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        default: begin
          resp     <= rx_shift;
          resp_rdy <= 1'b1;
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: table-driven TX/RX vectors with byte scoreboards, plus loopback and reset corner cases.
module tb_remote_comm;
  localparam int BAUD = 434;
  localparam int HALF = BAUD / 2;

  logic        clk;
  logic        rst_n;
  logic        rx_line;
  logic        rx_drv;
  logic        loop_en;
  logic        TX;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit  mon_en;
  int  snt_rises = 0;
  int  rdy_rises = 0;

  typedef struct {
    logic [15:0] cmd;
    bit          interfere;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
    int          exp_cyc;
  } tx_vec_t;

  typedef struct {
    logic [7:0] rx_byte;
    logic [7:0] exp_resp;
  } rx_vec_t;

  tx_vec_t tx_tab[2];
  rx_vec_t rx_tab[4];

  assign rx_line = loop_en ? TX : rx_drv;

  remote_comm #(.BAUD_DIV(BAUD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (rx_line),
    .TX       (TX),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // TX line decoder: pops the expected byte from the scoreboard for every frame seen.
  initial begin
    logic       prev_tx;
    logic [7:0] b;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev_tx && !TX) begin
        repeat (HALF) @(negedge clk);
        chk("tx_start_bit", TX, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        chk("tx_stop_bit", TX, 1'b1);
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_byte actual=%h required=none", b);
        end else begin
          chk("tx_byte", b, tx_q.pop_front());
        end
      end
      prev_tx = TX;
    end
  end

  // resp_rdy rising edge pops the expected response byte.
  initial begin
    logic prev_rdy, prev_snt;
    prev_rdy = 1'b0;
    prev_snt = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_snt && !prev_snt) snt_rises++;
      if (resp_rdy && !prev_rdy) begin
        rdy_rises++;
        if (rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_byte actual=%h required=none", resp);
        end else begin
          chk("resp_byte", resp, rx_q.pop_front());
        end
      end
      prev_rdy = resp_rdy;
      prev_snt = cmd_snt;
    end
  end

  task automatic do_send(input logic [15:0] c, input bit interfere,
                         input logic [7:0] hi, input logic [7:0] lo, input int exp_cyc);
    int n;
    int r0;
    bit got;
    @(negedge clk);
    cmd     = c;
    snd_cmd = 1'b1;
    tx_q.push_back(hi);
    tx_q.push_back(lo);
    r0  = snt_rises;
    n   = 0;
    got = 1'b0;
    while (n < 20000 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        snd_cmd = 1'b0;
        chk("cmd_snt_cleared", cmd_snt, 1'b0);
      end
      if (interfere && n == 1000) begin
        cmd     = 16'h1234;
        snd_cmd = 1'b1;
      end
      if (interfere && n == 1001) snd_cmd = 1'b0;
      got = cmd_snt;
    end
    chk("cmd_snt_latency", n, exp_cyc);
    repeat (50) @(negedge clk);
    chk("cmd_snt_hold", cmd_snt, 1'b1);
    chk("cmd_snt_rises", snt_rises - r0, 1);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic [7:0] prev);
    logic [9:0] frm;
    frm = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = frm[i];
      if (i == 0) begin
        repeat (10) @(negedge clk);
        chk("resp_rdy_clear_on_start", resp_rdy, 1'b0);
        repeat (BAUD - 10) @(negedge clk);
      end else begin
        if (i == 5) chk("resp_stable", resp, prev);
        repeat (BAUD) @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [7:0] last;
    int r0;
    tx_tab[0] = '{16'h6020, 1'b1, 8'h60, 8'h20, 8681};
    tx_tab[1] = '{16'h5A3C, 1'b0, 8'h5A, 8'h3C, 8681};
    rx_tab[0] = '{8'hA5, 8'hA5};
    rx_tab[1] = '{8'h00, 8'h00};
    rx_tab[2] = '{8'hFF, 8'hFF};
    rx_tab[3] = '{8'h3C, 8'h3C};

    rst_n   = 1'b1;
    snd_cmd = 1'b0;
    cmd     = 16'h0000;
    rx_drv  = 1'b1;
    loop_en = 1'b0;
    mon_en  = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_tx", TX, 1'b1);
    chk("rst_cmd_snt", cmd_snt, 1'b0);
    chk("rst_resp_rdy", resp_rdy, 1'b0);
    chk("rst_resp", resp, 8'h00);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_tx", TX, 1'b1);

    for (int i = 0; i < 2; i++)
      do_send(tx_tab[i].cmd, tx_tab[i].interfere, tx_tab[i].exp_hi, tx_tab[i].exp_lo, tx_tab[i].exp_cyc);

    last = 8'h00;
    for (int i = 0; i < 4; i++) begin
      rx_q.push_back(rx_tab[i].exp_resp);
      rx_frame(rx_tab[i].rx_byte, last);
      repeat (20) @(negedge clk);
      chk("resp_rdy_after_frame", resp_rdy, 1'b1);
      chk("resp_after_frame", resp, rx_tab[i].exp_resp);
      last = rx_tab[i].exp_resp;
    end

    // Loopback: both transmitted bytes come back through the receiver.
    loop_en = 1'b1;
    r0 = rdy_rises;
    rx_q.push_back(8'hFF);
    rx_q.push_back(8'hFF);
    do_send(16'hFFFF, 1'b0, 8'hFF, 8'hFF, 8681);
    repeat (2 * BAUD) @(negedge clk);
    chk("loop_rdy_pulses", rdy_rises - r0, 2);
    chk("loop_resp", resp, 8'hFF);
    loop_en = 1'b0;
    repeat (20) @(negedge clk);

    // Reset in the middle of the low byte.
    mon_en = 1'b0;
    @(negedge clk);
    cmd     = 16'hABCD;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (10 * BAUD + 1500) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_tx", TX, 1'b1);
    chk("midrst_cmd_snt", cmd_snt, 1'b0);
    chk("midrst_resp", resp, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (50) @(negedge clk);
    chk("postrst_tx", TX, 1'b1);
    chk("postrst_cmd_snt", cmd_snt, 1'b0);
    mon_en = 1'b1;
    do_send(16'h6020, 1'b0, 8'h60, 8'h20, 8681);

    repeat (10) @(negedge clk);
    chk("tx_queue_empty", tx_q.size(), 0);
    chk("rx_queue_empty", rx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
